ball_physics_engine: RTL and testbench

//  Per-frame ball physics and renderer for the VGA game pipeline, replacing the fixed-speed ball.

---
 rtl/ball_physics_engine_if.sv | 32 +++
 rtl/ball_physics_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_ball_physics_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ball_physics_engine_if.sv
// Game-side bundle for the ball engine: buttons, raster position and switches in; colour and ball state out.
interface ball_physics_engine_if;
  logic       button_c;
  logic       button_u;
  logic       button_d;
  logic       button_r;
  logic       button_l;
  logic [9:0] h_coord;
  logic [9:0] v_coord;
  logic [2:0] SW;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] vel_x;
  logic [7:0] vel_y;
  logic       bounce;
  logic       busy;

  modport master (
    output button_c, button_u, button_d, button_r, button_l,
    output h_coord, v_coord, SW,
    input  red, green, blue, ball_x, ball_y, vel_x, vel_y, bounce, busy
  );

  modport slave (
    input  button_c, button_u, button_d, button_r, button_l,
    input  h_coord, v_coord, SW,
    output red, green, blue, ball_x, ball_y, vel_x, vel_y, bounce, busy
  );
endinterface

// File: rtl/ball_physics_engine.sv
// Ball physics (impulse/move/bounce/friction, one state per cycle, once per FRAMES_PER_STEP frames)
// and a two-stage circle renderer: rgb follows h/v by exactly two pixel clocks.
module ball_physics_engine #(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 600,
  parameter int RADIUS          = 10,
  parameter int X0              = 300,
  parameter int Y0              = 400,
  parameter int FRAMES_PER_STEP = 2,
  parameter int IMPULSE         = 4,
  parameter int MAX_SPEED       = 15,
  parameter int DECEL_STEPS     = 8
) (
  input  logic                 pixel_clk,
  input  logic                 rst_n,
  ball_physics_engine_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IMPULSE,
    ST_MOVE,
    ST_BOUNCE,
    ST_FRICTION
  } state_e;

  localparam logic [9:0]         H_LAST     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]         V_LAST     = 10'(V_ACTIVE - 1);
  localparam logic [9:0]         H_END      = 10'(H_ACTIVE);
  localparam logic [9:0]         V_END      = 10'(V_ACTIVE);
  localparam logic [7:0]         FRAME_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0]         DECEL_N    = 8'(DECEL_STEPS);
  localparam logic signed [8:0]  IMP9       = 9'(IMPULSE);
  localparam logic signed [8:0]  VMAX       = 9'(MAX_SPEED);
  localparam logic signed [8:0]  VMIN       = -9'(MAX_SPEED);
  localparam logic signed [11:0] LO_LIM     = 12'(RADIUS);
  localparam logic signed [11:0] X_HI       = 12'(H_ACTIVE - 1 - RADIUS);
  localparam logic signed [11:0] Y_HI       = 12'(V_ACTIVE - 1 - RADIUS);
  localparam logic [9:0]         RAD_P      = 10'(RADIUS);
  localparam logic [9:0]         X_HI_P     = 10'(H_ACTIVE - 1 - RADIUS);
  localparam logic [9:0]         Y_HI_P     = 10'(V_ACTIVE - 1 - RADIUS);
  localparam logic [9:0]         X0_P       = 10'(X0);
  localparam logic [9:0]         Y0_P       = 10'(Y0);
  localparam logic [21:0]        R_SQ       = 22'(RADIUS * RADIUS);

  state_e             state_q, state_d;
  logic               eof_q, eof_d;
  logic               step_q, step_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]         decel_cnt_q, decel_cnt_d;
  logic [9:0]         ball_x_q, ball_x_d;
  logic [9:0]         ball_y_q, ball_y_d;
  logic signed [7:0]  vel_x_q, vel_x_d;
  logic signed [7:0]  vel_y_q, vel_y_d;
  logic signed [11:0] nx_q, nx_d;
  logic signed [11:0] ny_q, ny_d;
  logic               bounce_q, bounce_d;
  logic signed [8:0]  imp_x, imp_y;

  logic signed [10:0] dx_q, dx_d;
  logic signed [10:0] dy_q, dy_d;
  logic               active_q, active_d;
  logic signed [21:0] dx_w, dy_w, dx_sq, dy_sq;
  logic [21:0]        dist_sq;
  logic [3:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;

  // 9-bit sum cannot wrap for |v| <= 127 plus one impulse, so clamping afterwards is exact.
  function automatic logic signed [7:0] sat_vel(input logic signed [7:0] v,
                                                input logic signed [8:0] dv);
    logic signed [8:0] s;
    s = $signed({v[7], v}) + dv;
    if (s > VMAX)      return 8'(VMAX);
    else if (s < VMIN) return 8'(VMIN);
    else               return 8'(s);
  endfunction

  function automatic logic signed [7:0] toward_zero(input logic signed [7:0] v);
    if (v > 8'sd0)      return v - 8'sd1;
    else if (v < 8'sd0) return v + 8'sd1;
    else                return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    decel_cnt_d = decel_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    vel_x_d     = vel_x_q;
    vel_y_d     = vel_y_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    bounce_d    = 1'b0;
    step_d      = 1'b0;
    eof_d       = (bus.h_coord == H_LAST) && (bus.v_coord == V_LAST);
    imp_x       = (bus.button_r ? IMP9 : 9'sd0) - (bus.button_l ? IMP9 : 9'sd0);
    imp_y       = (bus.button_d ? IMP9 : 9'sd0) - (bus.button_u ? IMP9 : 9'sd0);

    if (eof_q) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        step_d      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE: if (step_q) state_d = ST_IMPULSE;
      ST_IMPULSE: begin
        if (bus.button_c) begin
          ball_x_d = X0_P;
          ball_y_d = Y0_P;
          vel_x_d  = '0;
          vel_y_d  = '0;
          state_d  = ST_IDLE;
        end else begin
          vel_x_d  = sat_vel(vel_x_q, imp_x);
          vel_y_d  = sat_vel(vel_y_q, imp_y);
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        nx_d    = $signed({2'b00, ball_x_q}) + $signed({{4{vel_x_q[7]}}, vel_x_q});
        ny_d    = $signed({2'b00, ball_y_q}) + $signed({{4{vel_y_q[7]}}, vel_y_q});
        state_d = ST_BOUNCE;
      end
      ST_BOUNCE: begin
        if (nx_q < LO_LIM) begin
          ball_x_d = RAD_P;
          vel_x_d  = -vel_x_q;
          bounce_d = 1'b1;
        end else if (nx_q > X_HI) begin
          ball_x_d = X_HI_P;
          vel_x_d  = -vel_x_q;
          bounce_d = 1'b1;
        end else begin
          ball_x_d = nx_q[9:0];
        end
        if (ny_q < LO_LIM) begin
          ball_y_d = RAD_P;
          vel_y_d  = -vel_y_q;
          bounce_d = 1'b1;
        end else if (ny_q > Y_HI) begin
          ball_y_d = Y_HI_P;
          vel_y_d  = -vel_y_q;
          bounce_d = 1'b1;
        end else begin
          ball_y_d = ny_q[9:0];
        end
        state_d = ST_FRICTION;
      end
      ST_FRICTION: begin
        if (DECEL_STEPS != 0) begin
          if (decel_cnt_q + 8'd1 == DECEL_N) begin
            decel_cnt_d = '0;
            vel_x_d     = toward_zero(vel_x_q);
            vel_y_d     = toward_zero(vel_y_q);
          end else begin
            decel_cnt_d = decel_cnt_q + 8'd1;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Draw stage 1: offsets from the ball centre; stage 2: circle test and colour select.
  always_comb begin
    dx_d     = $signed({1'b0, bus.h_coord}) - $signed({1'b0, ball_x_q});
    dy_d     = $signed({1'b0, bus.v_coord}) - $signed({1'b0, ball_y_q});
    active_d = (bus.h_coord < H_END) && (bus.v_coord < V_END);
    dx_w     = $signed({{11{dx_q[10]}}, dx_q});
    dy_w     = $signed({{11{dy_q[10]}}, dy_q});
    dx_sq    = dx_w * dx_w;
    dy_sq    = dy_w * dy_w;
    dist_sq  = $unsigned(dx_sq) + $unsigned(dy_sq);
    red_d    = 4'h0;
    green_d  = 4'h0;
    blue_d   = 4'h0;
    if (active_q) begin
      if (dist_sq <= R_SQ) begin
        red_d   = 4'hF;
        green_d = 4'hF;
        blue_d  = 4'hF;
      end else begin
        red_d   = bus.SW[0] ? 4'h3 : 4'h0;
        green_d = bus.SW[1] ? 4'h3 : 4'h0;
        blue_d  = bus.SW[2] ? 4'h3 : 4'h0;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      eof_q       <= 1'b0;
      step_q      <= 1'b0;
      frame_cnt_q <= '0;
      decel_cnt_q <= '0;
      ball_x_q    <= X0_P;
      ball_y_q    <= Y0_P;
      vel_x_q     <= '0;
      vel_y_q     <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      bounce_q    <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      active_q    <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      state_q     <= state_d;
      eof_q       <= eof_d;
      step_q      <= step_d;
      frame_cnt_q <= frame_cnt_d;
      decel_cnt_q <= decel_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      bounce_q    <= bounce_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      active_q    <= active_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign bus.ball_x = ball_x_q;
  assign bus.ball_y = ball_y_q;
  assign bus.vel_x  = vel_x_q;
  assign bus.vel_y  = vel_y_q;
  assign bus.bounce = bounce_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.red    = red_q;
  assign bus.green  = green_q;
  assign bus.blue   = blue_q;

endmodule

// File: tb/tb_ball_physics_engine.sv
// Directed bench for ball_physics_engine: step table with hand-computed ball state, draw table, reset corners.
module tb_ball_physics_engine;

  logic pixel_clk = 1'b0;
  logic rst_n;
  always #14 pixel_clk = ~pixel_clk;

  ball_physics_engine_if ifc();

  ball_physics_engine dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .bus       (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         rst;
    int         n;
    logic [4:0] btn;   // {c,u,d,r,l}
    int         x, y, vx, vy, bnc;
  } step_vec_t;

  typedef struct {
    logic [9:0]  h, v;
    logic [2:0]  sw;
    logic [11:0] rgb;
  } draw_vec_t;

  step_vec_t rows[31];
  draw_vec_t draws[11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_eof();
    ifc.h_coord = 10'd799;
    ifc.v_coord = 10'd599;
    @(negedge pixel_clk);
    ifc.h_coord = 10'd0;
    ifc.v_coord = 10'd0;
  endtask

  // One physics step = two end-of-frame pulses; busy/bounce are tallied across both frames.
  task automatic run_step(input logic [4:0] btn, output int busy_cyc, output int bnc_cyc);
    busy_cyc = 0;
    bnc_cyc  = 0;
    {ifc.button_c, ifc.button_u, ifc.button_d, ifc.button_r, ifc.button_l} = btn;
    for (int f = 0; f < 2; f++) begin
      pulse_eof();
      repeat (10) begin
        @(negedge pixel_clk);
        busy_cyc += int'(ifc.busy);
        bnc_cyc  += int'(ifc.bounce);
      end
    end
    {ifc.button_c, ifc.button_u, ifc.button_d, ifc.button_r, ifc.button_l} = 5'b0;
  endtask

  always @(negedge pixel_clk) begin
    if (rst_n === 1'b1 && dut.step_q === 1'b1 && ifc.busy === 1'b1) begin
      n_fail++;
      $display("FAIL step_while_busy: step seen with busy=%0b, required busy=0", ifc.busy);
    end
  end

  initial begin
    int bc, nc, busy_tot, bnc_tot, got;

    //            rst  n   cudrl     x    y    vx   vy  bnc
    rows[0]  = '{1'b1, 5, 5'b00000, 300, 400,   0,   0, 0};
    rows[1]  = '{1'b1, 1, 5'b00010, 304, 400,   4,   0, 0};
    rows[2]  = '{1'b0, 1, 5'b00010, 312, 400,   8,   0, 0};
    rows[3]  = '{1'b0, 1, 5'b00010, 324, 400,  12,   0, 0};
    rows[4]  = '{1'b0, 1, 5'b00010, 339, 400,  15,   0, 0};
    rows[5]  = '{1'b0, 1, 5'b00010, 354, 400,  15,   0, 0};
    rows[6]  = '{1'b0, 2, 5'b00010, 384, 400,  15,   0, 0};
    rows[7]  = '{1'b0, 1, 5'b00010, 399, 400,  14,   0, 0};
    rows[8]  = '{1'b0, 1, 5'b00010, 414, 400,  15,   0, 0};
    rows[9]  = '{1'b0,23, 5'b00010, 759, 400,  14,   0, 0};
    rows[10] = '{1'b0, 2, 5'b00010, 789, 400,  15,   0, 0};
    rows[11] = '{1'b0, 1, 5'b00000, 789, 400, -15,   0, 1};
    rows[12] = '{1'b0, 1, 5'b00000, 774, 400, -15,   0, 0};
    rows[13] = '{1'b0, 1, 5'b00011, 759, 400, -15,   0, 0};
    rows[14] = '{1'b0, 1, 5'b00001, 744, 400, -15,   0, 0};
    rows[15] = '{1'b0, 1, 5'b10010, 300, 400,   0,   0, 0};
    rows[16] = '{1'b1, 7, 5'b01000, 300, 316,   0, -15, 0};
    rows[17] = '{1'b0, 1, 5'b01001, 296, 301,  -3, -14, 0};
    rows[18] = '{1'b0, 3, 5'b01001, 263, 256, -15, -15, 0};
    rows[19] = '{1'b0, 5, 5'b01001, 188, 181, -14, -14, 0};
    rows[20] = '{1'b0,11, 5'b01001,  23,  16, -15, -15, 0};
    rows[21] = '{1'b0, 1, 5'b01001,  10,  10,  15,  15, 1};
    rows[22] = '{1'b0, 1, 5'b00000,  25,  25,  15,  15, 0};
    rows[23] = '{1'b1, 1, 5'b01010, 304, 396,   4,  -4, 0};
    rows[24] = '{1'b0, 7, 5'b00000, 332, 368,   3,  -3, 0};
    rows[25] = '{1'b0, 8, 5'b00000, 356, 344,   2,  -2, 0};
    rows[26] = '{1'b0, 8, 5'b00000, 372, 328,   1,  -1, 0};
    rows[27] = '{1'b0, 8, 5'b00000, 380, 320,   0,   0, 0};
    rows[28] = '{1'b0, 8, 5'b00000, 380, 320,   0,   0, 0};
    rows[29] = '{1'b0, 1, 5'b00100, 380, 324,   0,   4, 0};
    rows[30] = '{1'b0, 1, 5'b01100, 380, 328,   0,   4, 0};

    // Ball centred at (300,400), radius 10.
    draws[0]  = '{10'd310, 10'd400, 3'b000, 12'hFFF};
    draws[1]  = '{10'd311, 10'd400, 3'b101, 12'h303};
    draws[2]  = '{10'd300, 10'd390, 3'b010, 12'hFFF};
    draws[3]  = '{10'd300, 10'd389, 3'b010, 12'h030};
    draws[4]  = '{10'd306, 10'd408, 3'b111, 12'hFFF};
    draws[5]  = '{10'd307, 10'd408, 3'b111, 12'h333};
    draws[6]  = '{10'd290, 10'd400, 3'b000, 12'hFFF};
    draws[7]  = '{10'd289, 10'd400, 3'b001, 12'h300};
    draws[8]  = '{10'd800, 10'd400, 3'b111, 12'h000};
    draws[9]  = '{10'd100, 10'd600, 3'b111, 12'h000};
    draws[10] = '{10'd799, 10'd598, 3'b111, 12'h333};

    {ifc.button_c, ifc.button_u, ifc.button_d, ifc.button_r, ifc.button_l} = 5'b0;
    ifc.SW      = 3'b111;
    ifc.h_coord = 10'd310;
    ifc.v_coord = 10'd400;
    rst_n       = 1'b0;
    repeat (4) @(negedge pixel_clk);

    check("reset ball_x", int'(ifc.ball_x), 300);
    check("reset ball_y", int'(ifc.ball_y), 400);
    check("reset vel_x", int'($signed(ifc.vel_x)), 0);
    check("reset vel_y", int'($signed(ifc.vel_y)), 0);
    check("reset bounce", int'(ifc.bounce), 0);
    check("reset busy", int'(ifc.busy), 0);
    check("reset rgb", int'({ifc.red, ifc.green, ifc.blue}), 0);
    rst_n       = 1'b1;
    ifc.SW      = 3'b000;
    ifc.h_coord = 10'd0;
    ifc.v_coord = 10'd0;

    for (int i = 0; i < $size(rows); i++) begin
      if (rows[i].rst) do_reset();
      busy_tot = 0;
      bnc_tot  = 0;
      for (int k = 0; k < rows[i].n; k++) begin
        run_step(rows[i].btn, bc, nc);
        busy_tot += bc;
        bnc_tot  += nc;
      end
      check($sformatf("row%0d ball_x", i), int'(ifc.ball_x), rows[i].x);
      check($sformatf("row%0d ball_y", i), int'(ifc.ball_y), rows[i].y);
      check($sformatf("row%0d vel_x", i), int'($signed(ifc.vel_x)), rows[i].vx);
      check($sformatf("row%0d vel_y", i), int'($signed(ifc.vel_y)), rows[i].vy);
      check($sformatf("row%0d bounce_cycles", i), bnc_tot, rows[i].bnc);
      check($sformatf("row%0d busy_cycles", i), busy_tot,
            rows[i].n * (rows[i].btn[4] ? 1 : 4));
    end

    do_reset();
    for (int i = 0; i < $size(draws); i++) begin
      ifc.h_coord = draws[i].h;
      ifc.v_coord = draws[i].v;
      ifc.SW      = draws[i].sw;
      repeat (2) @(negedge pixel_clk);
      check($sformatf("draw%0d rgb", i), int'({ifc.red, ifc.green, ifc.blue}),
            int'(draws[i].rgb));
    end

    // Latency: a new pixel must not show after one cycle, and must after two.
    ifc.SW      = 3'b111;
    ifc.h_coord = 10'd100;
    ifc.v_coord = 10'd100;
    repeat (3) @(negedge pixel_clk);
    ifc.h_coord = 10'd310;
    ifc.v_coord = 10'd400;
    @(negedge pixel_clk);
    check("draw latency 1 cycle", int'({ifc.red, ifc.green, ifc.blue}), 'h333);
    @(negedge pixel_clk);
    check("draw latency 2 cycles", int'({ifc.red, ifc.green, ifc.blue}), 'hFFF);
    ifc.SW      = 3'b000;
    ifc.h_coord = 10'd0;
    ifc.v_coord = 10'd0;

    // Reset in the middle of a step discards the partial update.
    do_reset();
    ifc.button_r = 1'b1;
    pulse_eof();
    repeat (4) @(negedge pixel_clk);
    pulse_eof();
    got = 0;
    for (int k = 0; k < 8 && got == 0; k++) begin
      @(negedge pixel_clk);
      if (ifc.busy) got = 1;
    end
    check("midreset busy seen", got, 1);
    @(negedge pixel_clk);
    check("midreset vel_x before reset", int'($signed(ifc.vel_x)), 4);
    rst_n = 1'b0;
    @(negedge pixel_clk);
    rst_n        = 1'b1;
    ifc.button_r = 1'b0;
    check("midreset busy", int'(ifc.busy), 0);
    check("midreset vel_x", int'($signed(ifc.vel_x)), 0);
    check("midreset ball_x", int'(ifc.ball_x), 300);
    busy_tot = 0;
    repeat (8) begin
      @(negedge pixel_clk);
      busy_tot += int'(ifc.busy);
    end
    check("midreset no resume", busy_tot, 0);
    check("midreset ball_x settled", int'(ifc.ball_x), 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
